// File: rtl/vga_sync_receiver.sv
// Measures incoming VGA hsync/vsync timing, locks when it matches the configured
// mode for LOCK_FRAMES frames, and reports the visible-window pixel position.
module vga_sync_receiver #(
  parameter int H_TOTAL     = 800,
  parameter int H_SYNC      = 96,
  parameter int H_BP        = 48,
  parameter int H_ACTIVE    = 640,
  parameter int V_TOTAL     = 525,
  parameter int V_SYNC      = 2,
  parameter int V_BP        = 33,
  parameter int V_ACTIVE    = 480,
  parameter int LOCK_FRAMES = 2
) (
  input  logic        clk_25Mhz,
  input  logic        reset,
  input  logic        hsync_in,
  input  logic        vsync_in,
  output logic [15:0] h_count,
  output logic [15:0] v_count,
  output logic [15:0] line_length,
  output logic [15:0] frame_lines,
  output logic        locked,
  output logic        video_active,
  output logic [15:0] pixel_x,
  output logic [15:0] pixel_y,
  output logic        frame_start
);

  localparam logic [15:0] H_TOTAL_W = 16'(H_TOTAL);
  localparam logic [15:0] V_TOTAL_W = 16'(V_TOTAL);
  localparam logic [15:0] LOCK_W    = 16'(LOCK_FRAMES);
  localparam logic [15:0] H_TIMEOUT = 16'(2 * H_TOTAL);
  localparam logic [15:0] H_START   = 16'(H_SYNC + H_BP);
  localparam logic [15:0] H_END     = 16'(H_SYNC + H_BP + H_ACTIVE);
  localparam logic [15:0] V_START   = 16'(V_SYNC + V_BP);
  localparam logic [15:0] V_END     = 16'(V_SYNC + V_BP + V_ACTIVE);
  localparam logic [15:0] SAT       = 16'hFFFF;

  logic        hs_q, vs_q;
  logic [15:0] h_count_q, h_count_d;
  logic [15:0] v_count_q, v_count_d;
  logic [15:0] line_length_q, line_length_d;
  logic [15:0] frame_lines_q, frame_lines_d;
  logic [15:0] good_cnt_q, good_cnt_d;
  logic        frame_ok_q, frame_ok_d;
  logic        locked_q, locked_d;
  logic        frame_start_q;
  logic        hfall, vfall, line_ok, timeout;

  always_comb begin
    hfall         = hs_q & ~hsync_in;
    vfall         = vs_q & ~vsync_in;
    h_count_d     = h_count_q;
    v_count_d     = v_count_q;
    line_length_d = line_length_q;
    frame_lines_d = frame_lines_q;
    frame_ok_d    = frame_ok_q;
    good_cnt_d    = good_cnt_q;

    if (hfall) begin
      h_count_d     = '0;
      line_length_d = (h_count_q == SAT) ? SAT : h_count_q + 16'd1;
    end else if (h_count_q != SAT) begin
      h_count_d = h_count_q + 16'd1;
    end

    if (vfall) begin
      v_count_d     = '0;
      frame_lines_d = (hfall && v_count_q != SAT) ? v_count_q + 16'd1 : v_count_q;
    end else if (hfall && v_count_q != SAT) begin
      v_count_d = v_count_q + 16'd1;
    end

    // A line that closes on the same edge as vsync is judged by the frame check.
    line_ok = !hfall || (line_length_d == H_TOTAL_W);
    timeout = (h_count_q == H_TIMEOUT);

    if (timeout)                 frame_ok_d = 1'b0;
    else if (vfall)              frame_ok_d = 1'b1;
    else if (hfall && !line_ok)  frame_ok_d = 1'b0;

    if (timeout) begin
      good_cnt_d = '0;
    end else if (vfall) begin
      if (frame_ok_q && line_ok && frame_lines_d == V_TOTAL_W)
        good_cnt_d = (good_cnt_q == LOCK_W) ? good_cnt_q : good_cnt_q + 16'd1;
      else
        good_cnt_d = '0;
    end

    locked_d = (good_cnt_d == LOCK_W);
  end

  always_ff @(posedge clk_25Mhz or posedge reset) begin
    if (reset) begin
      hs_q          <= 1'b1;
      vs_q          <= 1'b1;
      h_count_q     <= SAT;
      v_count_q     <= SAT;
      line_length_q <= SAT;
      frame_lines_q <= SAT;
      good_cnt_q    <= '0;
      frame_ok_q    <= 1'b0;
      locked_q      <= 1'b0;
      frame_start_q <= 1'b0;
    end else begin
      hs_q          <= hsync_in;
      vs_q          <= vsync_in;
      h_count_q     <= h_count_d;
      v_count_q     <= v_count_d;
      line_length_q <= line_length_d;
      frame_lines_q <= frame_lines_d;
      good_cnt_q    <= good_cnt_d;
      frame_ok_q    <= frame_ok_d;
      locked_q      <= locked_d;
      frame_start_q <= vfall;
    end
  end

  assign video_active = locked_q
                      && (h_count_q >= H_START) && (h_count_q < H_END)
                      && (v_count_q >= V_START) && (v_count_q < V_END);

  assign pixel_x     = video_active ? h_count_q - H_START : '0;
  assign pixel_y     = video_active ? v_count_q - V_START : '0;
  assign h_count     = h_count_q;
  assign v_count     = v_count_q;
  assign line_length = line_length_q;
  assign frame_lines = frame_lines_q;
  assign locked      = locked_q;
  assign frame_start = frame_start_q;

endmodule

// File: tb/tb_vga_sync_receiver.sv
// Directed bench: 800-cycle lines with a short 6-line frame so that several lock,
// unlock, reset and timeout scenarios fit in a modest cycle count.
module tb_vga_sync_receiver;

  localparam int H_TOTAL     = 800;
  localparam int H_SYNC      = 96;
  localparam int H_BP        = 48;
  localparam int H_ACTIVE    = 640;
  localparam int V_TOTAL     = 6;
  localparam int V_SYNC      = 2;
  localparam int V_BP        = 1;
  localparam int V_ACTIVE    = 2;
  localparam int LOCK_FRAMES = 2;

  logic        clk_25Mhz = 1'b0;
  logic        reset;
  logic        hsync_in;
  logic        vsync_in;
  logic [15:0] h_count, v_count, line_length, frame_lines, pixel_x, pixel_y;
  logic        locked, video_active, frame_start;

  int n_tests = 0;
  int n_fail  = 0;

  // Stream position of the sample most recently clocked into the DUT.
  int cur_frame = 0, cur_line = 0, cur_col = 0;
  int last_frame = -1, last_line = -1, last_col = -1;
  int stretch_line = -1;

  vga_sync_receiver #(
    .H_TOTAL(H_TOTAL), .H_SYNC(H_SYNC), .H_BP(H_BP), .H_ACTIVE(H_ACTIVE),
    .V_TOTAL(V_TOTAL), .V_SYNC(V_SYNC), .V_BP(V_BP), .V_ACTIVE(V_ACTIVE),
    .LOCK_FRAMES(LOCK_FRAMES)
  ) dut (
    .clk_25Mhz   (clk_25Mhz),
    .reset       (reset),
    .hsync_in    (hsync_in),
    .vsync_in    (vsync_in),
    .h_count     (h_count),
    .v_count     (v_count),
    .line_length (line_length),
    .frame_lines (frame_lines),
    .locked      (locked),
    .video_active(video_active),
    .pixel_x     (pixel_x),
    .pixel_y     (pixel_y),
    .frame_start (frame_start)
  );

  always #5 clk_25Mhz = ~clk_25Mhz;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_tests++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
    end
  endtask

  task automatic drive(input logic hs, input logic vs);
    hsync_in = hs;
    vsync_in = vs;
    @(posedge clk_25Mhz);
    #1;
  endtask

  task automatic step();
    int len;
    len = (cur_line == stretch_line) ? H_TOTAL + 1 : H_TOTAL;
    drive((cur_col < H_SYNC) ? 1'b0 : 1'b1, (cur_line < V_SYNC) ? 1'b0 : 1'b1);
    last_frame = cur_frame;
    last_line  = cur_line;
    last_col   = cur_col;
    cur_col++;
    if (cur_col == len) begin
      cur_col = 0;
      cur_line++;
      if (cur_line == V_TOTAL) begin
        cur_line = 0;
        cur_frame++;
        stretch_line = -1;
      end
    end
  endtask

  task automatic run_to(input int f, input int l, input int c);
    int budget;
    budget = 20000;
    while (!(last_frame == f && last_line == l && last_col == c) && budget > 0) begin
      step();
      budget--;
    end
    n_tests++;
    assert (budget > 0) else begin
      n_fail++;
      $error("FAIL run_to: observed budget exhausted expected position %0d/%0d/%0d", f, l, c);
    end
  endtask

  initial begin
    reset    = 1'b1;
    hsync_in = 1'b1;
    vsync_in = 1'b1;
    #2;
    check("rst_h_count", h_count, 16'hFFFF);
    check("rst_v_count", v_count, 16'hFFFF);
    check("rst_line_length", line_length, 16'hFFFF);
    check("rst_frame_lines", frame_lines, 16'hFFFF);
    check("rst_locked", locked, 0);
    check("rst_frame_start", frame_start, 0);
    check("rst_video_active", video_active, 0);
    check("rst_pixel_x", pixel_x, 0);

    repeat (2) @(posedge clk_25Mhz);
    #1;
    reset = 1'b0;
    drive(1'b1, 1'b1);

    // First vsync/hsync fall after reset; h_count was saturated.
    run_to(0, 0, 0);
    check("f0_h_count", h_count, 0);
    check("f0_v_count", v_count, 0);
    check("f0_line_length_sat", line_length, 16'hFFFF);
    check("f0_frame_start", frame_start, 1);
    check("f0_locked", locked, 0);
    step();
    check("f0_frame_start_drop", frame_start, 0);
    check("f0_h_count_inc", h_count, 1);

    run_to(1, 0, 0);
    check("f1_line_length", line_length, 800);
    check("f1_frame_lines", frame_lines, 6);
    check("f1_locked", locked, 0);
    run_to(1, 5, 799);
    check("f1_end_locked", locked, 0);
    step();
    check("f2_locked", locked, 1);

    // Asynchronous reset mid-line while locked.
    run_to(2, 2, 300);
    reset = 1'b1;
    #2;
    check("arst_h_count", h_count, 16'hFFFF);
    check("arst_v_count", v_count, 16'hFFFF);
    check("arst_line_length", line_length, 16'hFFFF);
    check("arst_frame_lines", frame_lines, 16'hFFFF);
    check("arst_locked", locked, 0);
    check("arst_video_active", video_active, 0);
    step();
    reset = 1'b0;

    run_to(3, 0, 0);
    check("f3_locked", locked, 0);
    check("f3_line_length", line_length, 800);
    run_to(4, 0, 0);
    check("f4_locked", locked, 0);
    check("f4_frame_lines", frame_lines, 6);
    run_to(5, 0, 0);
    check("f5_locked", locked, 1);

    // Visible-window boundaries (h 144..783, v 3..4).
    run_to(5, 2, 200);
    check("win_v_below", video_active, 0);
    run_to(5, 3, 143);
    check("win_h_below", video_active, 0);
    check("win_h_below_px", pixel_x, 0);
    run_to(5, 3, 144);
    check("win_first_active", video_active, 1);
    check("win_first_px", pixel_x, 0);
    check("win_first_py", pixel_y, 0);
    stretch_line = 4;
    run_to(5, 4, 783);
    check("win_last_active", video_active, 1);
    check("win_last_px", pixel_x, 639);
    check("win_last_py", pixel_y, 1);
    run_to(5, 4, 784);
    check("win_h_above", video_active, 0);
    check("win_h_above_px", pixel_x, 0);

    // Line 4 runs 801 cycles: lock holds until the next vsync.
    run_to(5, 5, 0);
    check("stretch_line_length", line_length, 801);
    check("stretch_locked_hold", locked, 1);
    run_to(5, 5, 200);
    check("win_v_above", video_active, 0);
    run_to(5, 5, 799);
    check("stretch_locked_end", locked, 1);
    run_to(6, 0, 0);
    check("f6_unlocked", locked, 0);
    check("f6_v_count", v_count, 0);
    check("f6_frame_lines", frame_lines, 6);
    check("f6_frame_start", frame_start, 1);
    step();
    check("f6_frame_start_once", frame_start, 0);
    run_to(7, 0, 0);
    check("f7_locked", locked, 0);
    check("f7_line_length", line_length, 800);
    run_to(8, 0, 0);
    check("f8_relocked", locked, 1);

    // hsync stuck high: lock drops one edge after h_count reaches 1600.
    run_to(8, 2, 100);
    repeat (1500) drive(1'b1, 1'b1);
    check("to_h_count", h_count, 1600);
    check("to_locked_before", locked, 1);
    drive(1'b1, 1'b1);
    check("to_locked_after", locked, 0);
    check("to_h_count_next", h_count, 1601);

    // hsync stuck low: one fall, then no further reloads.
    drive(1'b0, 1'b1);
    check("low_h_count", h_count, 0);
    check("low_line_length", line_length, 1602);
    repeat (10) drive(1'b0, 1'b1);
    check("low_h_count_run", h_count, 10);
    check("low_locked", locked, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/vga_sync_receiver.md
VGA_SYNC_RECEIVER -- requirements
Module: vga_sync_receiver

Interface
REQ-001 Parameters (name, default, meaning), SHALL be: H_TOTAL, 800, expected cycles per line; H_SYNC, 96, hsync low width; H_BP, 48, back porch; H_ACTIVE, 640, visible pixels.
REQ-002 Parameters SHALL also be: V_TOTAL, 525, expected lines per frame; V_SYNC, 2; V_BP, 33; V_ACTIVE, 480; LOCK_FRAMES, 2, consecutive good frames to lock.
REQ-003 clk_25Mhz  input  1  sole clock; all state changes on its rising edge.
REQ-004 reset  input  1  asynchronous, active-high reset.
REQ-005 hsync_in  input  1  active-low horizontal sync, synchronous to clk_25Mhz.
REQ-006 vsync_in  input  1  active-low vertical sync, synchronous to clk_25Mhz.
REQ-007 h_count  output  16  cycles since last hsync falling edge.
REQ-008 v_count  output  16  hsync falling edges since last vsync falling edge.
REQ-009 line_length  output  16  last measured line period in cycles.
REQ-010 frame_lines  output  16  last measured lines per frame.
REQ-011 locked  output  1  timing matches parameters for LOCK_FRAMES consecutive frames.
REQ-012 video_active  output  1  current position is in the visible window while locked.
REQ-013 pixel_x, pixel_y  output  16 each  visible-area coordinates; 0 when video_active=0.
REQ-014 frame_start  output  1  one-cycle pulse on each vsync falling edge.

Function
REQ-015 Edge detect: hs_q/vs_q SHALL register previous input; hfall = hs_q & ~hsync_in; vfall = vs_q & ~vsync_in (first low sample after a high).
REQ-016 On hfall, h_count SHALL load 0 at that clock edge; otherwise it increments, saturating at 16'hFFFF.
REQ-017 On hfall, line_length SHALL load h_count+1 (16-bit); if h_count=16'hFFFF, line_length SHALL load 16'hFFFF.
REQ-018 On vfall, v_count SHALL load 0; else on hfall it increments, saturating at 16'hFFFF; simultaneous vfall and hfall: v_count loads 0.
REQ-019 On vfall, frame_lines SHALL load v_count + (hfall ? 1 : 0).
REQ-020 frame_ok flag: on vfall set to 1; on any hfall without vfall whose loaded line_length != H_TOTAL, clear to 0.
REQ-021 good_cnt (saturating at LOCK_FRAMES): on vfall, increment if frame_ok=1, the hfall-derived line_length check passes, and new frame_lines == V_TOTAL; else clear to 0.
REQ-022 locked SHALL be registered, 1 exactly when good_cnt == LOCK_FRAMES.
REQ-023 Timeout: when h_count reaches 2*H_TOTAL, good_cnt and locked SHALL clear on the next edge and frame_ok SHALL clear.
REQ-024 video_active SHALL be combinational: locked & (H_SYNC+H_BP <= h_count < H_SYNC+H_BP+H_ACTIVE) & (V_SYNC+V_BP <= v_count < V_SYNC+V_BP+V_ACTIVE).
REQ-025 pixel_x = h_count-(H_SYNC+H_BP), pixel_y = v_count-(V_SYNC+V_BP) when video_active, else 0.
REQ-026 frame_start SHALL be registered: 1 for exactly the cycle after vfall is sampled, else 0.
REQ-027 Sync inputs held low indefinitely SHALL produce no further hfall/vfall; counters saturate, lock drops via REQ-023.

Reset
REQ-028 On reset assertion, asynchronously: h_count=v_count=line_length=frame_lines=16'hFFFF; hs_q=vs_q=1; good_cnt=0, frame_ok=0; locked=0, frame_start=0.
REQ-029 Reset mid-frame SHALL discard all measurements; the frame in progress at reset release never counts toward lock.

Verification
REQ-030 Standard 640x480 stimulus (800x525, hsync low 96, vsync low 2 lines) -> locked=1 after the 3rd vfall post-reset; line_length=800, frame_lines=525 thereafter.
REQ-031 While locked, h_count=144, v_count=35 -> video_active=1, pixel_x=0, pixel_y=0; h_count=783, v_count=514 -> pixel_x=639, pixel_y=479; h_count=784 -> video_active=0.
REQ-032 One line stretched to 801 cycles while locked -> line_length=801, locked stays 1 until next vfall, then 0; relocks after 2 further clean frames.
REQ-033 hsync held high for 1600 cycles -> locked=0 on following edge; h_count saturates at 16'hFFFF after 65535 cycles.
REQ-034 vfall coincident with hfall -> v_count=0, frame_lines=previous v_count+1, frame_start pulses once.
REQ-035 reset asserted mid-line while locked -> outputs take REQ-028 values immediately without a clock edge.
